// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - fetch/load-store sequencer for the unified ROM/RAM memory
module mem_access_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE   = 32'h1000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  fetch_done_o,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic                  ls_done_o,
    output logic                  addr_err_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    accept_ls, accept_fetch, accept;
    logic [DATA_WIDTH-1:0]   req_addr;
    logic                    req_err;
    logic                    lat_ls, lat_store, lat_err;
    logic                    we_nxt, fetch_done_nxt, ls_done_nxt, err_nxt, busy_nxt;

    // Load/store wins over a simultaneous fetch; requests are only looked at in IDLE.
    always_comb begin
        accept_ls    = (state == IDLE) && ls_req_i;
        accept_fetch = (state == IDLE) && !ls_req_i && fetch_req_i;
        accept       = accept_ls || accept_fetch;
        req_addr     = accept_ls ? ls_addr_i : pc_i;
        req_err      = (req_addr[1:0] != 2'b00) ||
                       (accept_ls && ls_we_i && (req_addr < RAM_BASE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        we_nxt         = accept_ls && ls_we_i && !req_err;
        fetch_done_nxt = (state == ACCESS) && !lat_ls;
        ls_done_nxt    = (state == ACCESS) && lat_ls;
        err_nxt        = (state == ACCESS) && lat_err;
        busy_nxt       = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_we_o     <= 1'b0;
            instr_o      <= NOP_INSTR;
            ld_data_o    <= '0;
            fetch_done_o <= 1'b0;
            ls_done_o    <= 1'b0;
            addr_err_o   <= 1'b0;
            busy_o       <= 1'b0;
            lat_ls       <= 1'b0;
            lat_store    <= 1'b0;
            lat_err      <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr_o <= req_addr;
                lat_ls     <= accept_ls;
                lat_store  <= accept_ls && ls_we_i;
                lat_err    <= req_err;
            end
            if (accept_ls && ls_we_i) begin
                mem_wdata_o <= ls_wdata_i;
            end
            // Read data is valid during ACCESS; an erroring request captures nothing.
            if (state == ACCESS && !lat_err) begin
                if (!lat_ls) begin
                    instr_o <= mem_rdata_i;
                end else if (!lat_store) begin
                    ld_data_o <= mem_rdata_i;
                end
            end
            mem_we_o     <= we_nxt;
            fetch_done_o <= fetch_done_nxt;
            ls_done_o    <= ls_done_nxt;
            addr_err_o   <= err_nxt;
            busy_o       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req_i, ls_req_i, ls_we_i;
    logic [31:0] pc_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
    logic [31:0] mem_addr_o, mem_wdata_o, instr_o, ld_data_o;
    logic        mem_we_o, fetch_done_o, ls_done_o, addr_err_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_instr, exp_ld, exp_wdata;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req_i  (fetch_req_i),
        .pc_i         (pc_i),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .instr_o      (instr_o),
        .fetch_done_o (fetch_done_o),
        .ld_data_o    (ld_data_o),
        .ls_done_o    (ls_done_o),
        .addr_err_o   (addr_err_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_instr = NOP_INSTR;
        exp_ld    = '0;
        exp_wdata = '0;
    endtask

    // One complete request issued from an IDLE cycle; returns in the following IDLE cycle.
    task automatic do_txn(input bit is_ls, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
        bit err;
        err = (addr % 4 != 0) || (is_ls && we && addr < RAM_BASE);
        chk("idle_busy", busy_o, 0);
        if (is_ls) begin
            fetch_req_i = 1'b0; ls_req_i = 1'b1; ls_we_i = we;
            ls_addr_i = addr; ls_wdata_i = wdata;
            if (we) exp_wdata = wdata;
        end else begin
            ls_req_i = 1'b0; fetch_req_i = 1'b1; pc_i = addr;
        end
        mem_rdata_i = rdata;
        tick();
        chk("acc_addr", mem_addr_o, addr);
        chk("acc_we", mem_we_o, (is_ls && we && !err) ? 1 : 0);
        chk("acc_wdata", mem_wdata_o, exp_wdata);
        chk("acc_busy", busy_o, 1);
        chk("acc_fdone", fetch_done_o, 0);
        chk("acc_lsdone", ls_done_o, 0);
        if (!err) begin
            if (!is_ls) exp_instr = rdata;
            else if (!we) exp_ld = rdata;
        end
        tick();
        chk("resp_fdone", fetch_done_o, is_ls ? 0 : 1);
        chk("resp_lsdone", ls_done_o, is_ls ? 1 : 0);
        chk("resp_err", addr_err_o, err ? 1 : 0);
        chk("resp_we", mem_we_o, 0);
        chk("resp_busy", busy_o, 1);
        chk("resp_instr", instr_o, exp_instr);
        chk("resp_ld", ld_data_o, exp_ld);
        tick();
        chk("post_fdone", fetch_done_o, 0);
        chk("post_lsdone", ls_done_o, 0);
        chk("post_err", addr_err_o, 0);
    endtask

    initial begin
        int          cyc;
        int          kind;
        logic [31:0] a;

        rst_n = 1'b0;
        fetch_req_i = 0; ls_req_i = 0; ls_we_i = 0;
        pc_i = 0; ls_addr_i = 0; ls_wdata_i = 0; mem_rdata_i = 0;
        model_reset();
        #12;
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_instr", instr_o, NOP_INSTR);
        chk("rst_ld", ld_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pulses", {fetch_done_o, ls_done_o, addr_err_o}, 0);
        rst_n = 1'b1;
        tick();

        do_txn(0, 0, 32'h0000_0004, 32'h0, 32'h0050_0093);
        do_txn(1, 1, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0);
        do_txn(1, 1, 32'h0000_0010, 32'h1111_2222, 32'h0);
        do_txn(1, 0, 32'h1000_0002, 32'h0, 32'hAAAA_5555);
        do_txn(1, 0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D);
        do_txn(1, 1, 32'h0FFF_FFFC, 32'h3333_4444, 32'h0);
        do_txn(1, 1, 32'h1000_0000, 32'h5555_6666, 32'h0);
        do_txn(0, 0, 32'h0000_0006, 32'h0, 32'h7777_7777);

        // Back-to-back fetches with req held high, address switched after each done
        do_txn(0, 0, 32'h0000_0000, 32'h0, 32'h0000_0113);
        do_txn(0, 0, 32'h0000_0004, 32'h0, 32'h0000_0213);
        do_txn(0, 0, 32'h0000_0008, 32'h0, 32'h0000_0313);
        fetch_req_i = 0;
        tick();

        // Simultaneous fetch and load: load first, fetch three cycles after ls_done
        fetch_req_i = 1; pc_i = 32'h0000_0040;
        ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h1000_0000;
        mem_rdata_i = 32'h1234_5678;
        tick();
        chk("sim_addr", mem_addr_o, 32'h1000_0000);
        tick();
        chk("sim_lsdone", ls_done_o, 1);
        chk("sim_fdone0", fetch_done_o, 0);
        chk("sim_ld", ld_data_o, 32'h1234_5678);
        exp_ld = 32'h1234_5678;
        tick();
        ls_req_i = 0;
        mem_rdata_i = 32'hCAFE_0013;
        cyc = 1;
        while (!fetch_done_o && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("sim_fdone_lat", cyc, 3);
        chk("sim_instr", instr_o, 32'hCAFE_0013);
        exp_instr = 32'hCAFE_0013;
        fetch_req_i = 0;
        tick();

        // Reset during the ACCESS cycle of a store
        ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h1000_0020; ls_wdata_i = 32'h0F0F_0F0F;
        tick();
        chk("mid_we_pre", mem_we_o, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_we", mem_we_o, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_instr", instr_o, NOP_INSTR);
        ls_req_i = 0;
        tick();
        tick();
        chk("mid_nodone", {fetch_done_o, ls_done_o, addr_err_o}, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_idle", busy_o, 0);

        // Randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: a = RAM_BASE + ($urandom & 32'h00FF_FFFC);
                1: a = $urandom & 32'h0FFF_FFFC;
                2: a = $urandom | 32'h1;
                default: a = $urandom;
            endcase
            do_txn(kind != 0, kind == 2, a, $urandom, $urandom);
        end
        fetch_req_i = 0; ls_req_i = 0;
        tick();
        chk("end_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Upstream sequencer for the unified ROM/RAM memory system. It arbitrates between instruction-fetch and load/store requests from the core and drives the memory's address, write-data and write-enable inputs. It captures the memory read output into an instruction register or a load-data register. It also blocks illegal stores to the ROM region (below RAM_BASE) and flags misaligned word accesses.

Parameters:
DATA_WIDTH, 32, width of address and data paths
RAM_BASE, 32'h1000_0000, first RAM address; addresses below it are ROM (read-only)
NOP_INSTR, 32'h0000_0013, reset/idle value of instr_o

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req_i  input  1  fetch request; held high until fetch_done_o
pc_i  input  DATA_WIDTH  fetch address
ls_req_i  input  1  load/store request; held high until ls_done_o
ls_we_i  input  1  1 = store, 0 = load
ls_addr_i  input  DATA_WIDTH  load/store address
ls_wdata_i  input  DATA_WIDTH  store data
mem_rdata_i  input  DATA_WIDTH  memory read data (combinational from memory system)
mem_addr_o  output  DATA_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_we_o  output  1  memory write enable
instr_o  output  DATA_WIDTH  instruction register
fetch_done_o  output  1  one-cycle pulse: fetch complete
ld_data_o  output  DATA_WIDTH  load-data register
ls_done_o  output  1  one-cycle pulse: load/store complete
addr_err_o  output  1  one-cycle pulse with a done pulse: request rejected
busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_addr_o=0, mem_wdata_o=0, mem_we_o=0; instr_o=NOP_INSTR; ld_data_o=0; all pulses=0; busy_o=0. mem_we_o drops immediately on reset assertion, so an in-flight store is aborted.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE: requests are sampled only in this state. If ls_req_i=1, the load/store is accepted; this takes priority over a simultaneous fetch_req_i. Otherwise, if fetch_req_i=1, the fetch is accepted. On acceptance at edge k:
  - mem_addr_o is loaded with the request address.
  - mem_wdata_o is loaded with ls_wdata_i (stores only).
  - The request type and the error check result are latched.
  - The state moves to ACCESS.
- Error check at acceptance: any access with addr[1:0]!=0 is an error. A store with addr < RAM_BASE (unsigned compare) is also an error.
- ACCESS (cycle k+1):
  - mem_addr_o is stable.
  - mem_we_o=1 only for a non-error store; it is 0 in every other state and case.
  - At the end of the cycle, a non-error fetch captures mem_rdata_i into instr_o, and a non-error load captures mem_rdata_i into ld_data_o.
  - The state moves to RESP.
- RESP (cycle k+2):
  - fetch_done_o or ls_done_o pulses high for exactly one cycle.
  - addr_err_o pulses in the same cycle if the request was an error. An erroring request leaves instr_o and ld_data_o unchanged and performs no write.
  - The state returns to IDLE.
- Latency: request-to-done is 2 cycles. Maximum throughput is one request per 3 cycles.
- Requesters keep req high through their done cycle and must deassert it in the cycle after done, unless issuing a new request.
- mem_addr_o and mem_wdata_o hold their last values in IDLE and RESP. instr_o and ld_data_o hold until the next successful capture.
- Loads from the ROM region are legal.
- Address wrap: none; the full 32-bit address is passed through unchanged.
- Starvation: back-to-back ls requests delay fetch indefinitely, by design. The core serialises its own requests.

Test Plan:
- Reset then fetch: fetch_req_i=1, pc_i=0x0000_0004, mem_rdata_i=0x0050_0093 -> mem_addr_o=0x4 in cycle k+1; fetch_done_o=1 and instr_o=0x0050_0093 in cycle k+2; busy_o=1 in cycles k+1 and k+2.
- Store to RAM: ls_req_i=1, ls_we_i=1, ls_addr_i=0x1000_0008, ls_wdata_i=0xDEAD_BEEF -> mem_we_o=1 for exactly cycle k+1 with mem_addr_o=0x1000_0008 and mem_wdata_o=0xDEAD_BEEF; ls_done_o=1 and addr_err_o=0 in cycle k+2.
- Illegal stores: store to 0x0000_0010 -> mem_we_o stays 0; ls_done_o=1 and addr_err_o=1 in cycle k+2. Load from 0x1000_0002 -> addr_err_o=1 and ld_data_o unchanged.
- Simultaneous requests: fetch_req_i=1 and ls_req_i=1 (load 0x1000_0000, mem_rdata_i=0x1234_5678) in the same IDLE cycle -> ls_done_o pulses first with ld_data_o=0x1234_5678; the fetch is accepted in the following IDLE cycle and fetch_done_o pulses 3 cycles later.
- Reset mid-store: assert rst_n=0 during ACCESS of a store -> mem_we_o=0 immediately, no done pulse, instr_o=0x0000_0013, busy_o=0.
- Back-to-back fetches: fetch_req_i held high for PCs 0x0, 0x4, 0x8 (switched after each done) -> fetch_done_o pulses every 3rd cycle with matching instr_o values.
